button_conditioner: RTL and testbench

//  Conditions the raw active-low arcade push-buttons ahead of the game controller.
//  Per channel: 2-FF synchronizer, then a debounce counter, then edge detection.

---
 rtl/button_conditioner.sv | 110 +++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - active-low push-button synchronizer, debouncer and press/release pulser (optional HOLD_REPEAT_EN auto-repeat)
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] fire;
  logic [N_BTN-1:0] press_next;

  // Two-stage synchronizer; inversion at entry makes everything downstream active-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~btn_raw;
      s2 <= s1;
    end
  end

  // A channel accepts its new level when it has differed for a full window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (s2[i] != btn_level[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  // Debounce counters and the accepted level; any agreement restarts the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          btn_level[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  logic [RW-1:0] rpt [N_BTN];

  // Repeat fires only while held, and never on the edge that accepts a release.
  always_comb begin
    fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      fire[i] = btn_level[i] && !accept[i] && (rpt[i] == RW'(REPEAT_DELAY - 1));
    end
  end

  // Hold-time counter; reloads so later repeats are spaced by REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) rpt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (accept[i])          rpt[i] <= '0;
        else if (fire[i])       rpt[i] <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
        else if (btn_level[i])  rpt[i] <= rpt[i] + 1'b1;
      end
    end
  end
`else
  localparam int REPEAT_SUM = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_SUM != 0);
  assign fire = '0;
`endif

  assign press_next = (accept & s2) | fire;

  // Registered strobes so no combinational path reaches the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_pulse   <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
    end else begin
      press_pulse   <= press_next;
      release_pulse <= accept & ~s2;
      any_press     <= |press_next;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
  localparam int N  = 5;
  localparam int D  = 8;
  localparam int RD = 32;
  localparam int RP = 10;
`ifdef HOLD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, press_pulse, release_pulse;
  logic         any_press;

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .any_press(any_press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: delayed input, run length of disagreement, repeat schedule by arithmetic.
  logic [N-1:0] m_d1, m_d2, m_level, m_press, m_release;
  logic         m_any;
  int           run [N];
  int           tp  [N];

  always @(posedge clk) begin
    edge_no = edge_no + 1;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) begin run[i] = 0; tp[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_press[i] = 1'b0;
        m_release[i] = 1'b0;
        if (m_d2[i] != m_level[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (run[i] == D) begin
          m_level[i] = m_d2[i];
          run[i] = 0;
          if (m_d2[i]) begin m_press[i] = 1'b1; tp[i] = edge_no; end
          else m_release[i] = 1'b1;
        end else if (REP_EN && m_level[i] && (edge_no - tp[i]) >= RD &&
                     ((edge_no - tp[i] - RD) % RP) == 0) begin
          m_press[i] = 1'b1;
        end
      end
      m_any = |m_press;
      m_d2 = m_d1;
      m_d1 = ~btn_raw;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (edge_no > 0) begin
      total++;
      if ({btn_level, press_pulse, release_pulse, any_press} !== {m_level, m_press, m_release, m_any}) begin
        bad++;
        $display("FAIL model_cmp edge %0d: got lvl=%b p=%b r=%b a=%b expected lvl=%b p=%b r=%b a=%b",
                 edge_no, btn_level, press_pulse, release_pulse, any_press,
                 m_level, m_press, m_release, m_any);
      end
    end
  end

  // Event log of DUT pulses for the literal checks.
  int pcnt [N];
  int rcnt [N];
  int pe   [N][8];
  int re   [N];
  int acnt;

  always @(negedge clk) begin
    if (edge_no > 0) begin
      for (int i = 0; i < N; i++) begin
        if (press_pulse[i] === 1'b1) begin
          if (pcnt[i] < 8) pe[i][pcnt[i]] = edge_no;
          pcnt[i] = pcnt[i] + 1;
        end
        if (release_pulse[i] === 1'b1) begin
          re[i] = edge_no;
          rcnt[i] = rcnt[i] + 1;
        end
      end
      if (any_press === 1'b1) acnt = acnt + 1;
    end
  end

  task automatic clear_log();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0; rcnt[i] = 0; re[i] = -1;
      for (int j = 0; j < 8; j++) pe[i][j] = -1;
    end
    acnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0, t1, tf;
  int rep_edges [6];

  initial begin
    rep_edges[0] = 9;  rep_edges[1] = 41; rep_edges[2] = 51;
    rep_edges[3] = 61; rep_edges[4] = 71; rep_edges[5] = 81;
    clear_log();
    reset = 1'b1;
    btn_raw = '1;
    idle(3);
    reset = 1'b0;
    chk("reset_state", int'({btn_level, press_pulse, release_pulse, any_press}), 0);
    idle(3);

    // 1: clean press and release on channel 0
    clear_log();
    btn_raw[0] = 1'b0; t0 = edge_no + 1;
    idle(20);
    chk("t1_press_cnt", pcnt[0], 1);
    chk("t1_press_edge", pe[0][0] - t0, 9);
    chk("t1_any_cnt", acnt, 1);
    chk("t1_level", int'(btn_level), 1);
    btn_raw[0] = 1'b1; t1 = edge_no + 1;
    idle(12);
    chk("t1_release_edge", re[0] - t1, 9);
    chk("t1_level_off", int'(btn_level), 0);

    // 2: glitch of 7 rejected, 8 accepted
    clear_log();
    btn_raw[2] = 1'b0;
    idle(7);
    btn_raw[2] = 1'b1;
    idle(15);
    chk("t2_glitch_press", pcnt[2], 0);
    chk("t2_glitch_level", int'(btn_level[2]), 0);
    clear_log();
    btn_raw[2] = 1'b0; t0 = edge_no + 1;
    idle(8);
    btn_raw[2] = 1'b1; t1 = edge_no + 1;
    idle(15);
    chk("t2_press_edge", pe[2][0] - t0, 9);
    chk("t2_press_cnt", pcnt[2], 1);
    chk("t2_release_edge", re[2] - t1, 9);
    chk("t2_release_after_press", re[2] - pe[2][0], 8);

    // 3: bounce restarts the window
    clear_log();
    btn_raw[1] = 1'b0; idle(3);
    btn_raw[1] = 1'b1; idle(3);
    btn_raw[1] = 1'b0; idle(3);
    btn_raw[1] = 1'b1; idle(3);
    btn_raw[1] = 1'b0; tf = edge_no + 1;
    idle(15);
    chk("t3_press_cnt", pcnt[1], 1);
    chk("t3_press_edge", pe[1][0] - tf, 9);
    btn_raw[1] = 1'b1;
    idle(12);

    // 4: all channels at once
    clear_log();
    btn_raw = '0; t0 = edge_no + 1;
    idle(12);
    for (int i = 0; i < N; i++) chk($sformatf("t4_press_edge_%0d", i), pe[i][0] - t0, 9);
    chk("t4_any_cnt", acnt, 1);
    chk("t4_level", int'(btn_level), 31);
    btn_raw = '1;
    idle(12);

    // 5: reset mid-count discards the partial transition
    clear_log();
    btn_raw[3] = 1'b0; t0 = edge_no + 1;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(15);
    chk("t5_press_cnt", pcnt[3], 1);
    chk("t5_press_edge", pe[3][0] - t0, 15);
    btn_raw[3] = 1'b1;
    idle(12);

    // 6: long hold, auto-repeat when enabled
    clear_log();
    btn_raw[0] = 1'b0; t0 = edge_no + 1;
    idle(80);
    btn_raw[0] = 1'b1;
    idle(15);
    if (REP_EN) begin
      chk("t6_press_cnt", pcnt[0], 6);
      for (int j = 0; j < 6; j++) chk($sformatf("t6_rep_edge_%0d", j), pe[0][j] - t0, rep_edges[j]);
    end else begin
      chk("t6_press_cnt", pcnt[0], 1);
      chk("t6_press_edge", pe[0][0] - t0, 9);
    end
    chk("t6_release_cnt", rcnt[0], 1);
    chk("t6_release_edge", re[0] - t0, 89);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
